spi_sub_buf_ctrl: RTL and testbench
===================================

SPI_SUB_BUF_CTRL -- requirements
Module: spi_sub_buf_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per FIFO; power of 2, minimum 2.
REQ-002 SHALL have parameter DUMMY_BYTE, default 8'hFF, byte driven on sub_tx when no data is staged.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 pclk  input  1  clock; all state updates on rising edge.
REQ-005 presetn  input  1  synchronous active-low reset.
REQ-006 tx_data  input  8  host byte to transmit.
REQ-007 tx_valid  input  1  host offers tx_data.
REQ-008 tx_ready  output  1  TX FIFO can accept; push on tx_valid&tx_ready.
REQ-009 rx_data  output  8  head of RX FIFO.
REQ-010 rx_valid  output  1  RX FIFO non-empty.
REQ-011 rx_ready  input  1  host pops on rx_valid&rx_ready.
REQ-012 sub_tx  output  8  staged byte presented to the subordinate shifter.
REQ-013 load_from_fifo  input  1  one-cycle pulse: shifter consumed sub_tx this cycle.
REQ-014 sub_rx  input  8  byte received by the shifter.
REQ-015 fifo_load  input  1  one-cycle pulse: sub_rx holds a complete byte.
REQ-016 tx_level, rx_level  output  $clog2(DEPTH)+1 each  FIFO occupancies; tx_level excludes the staged byte.
REQ-017 tx_underflow, rx_overflow  output  1 each  error flags.
REQ-018 err_clr  input  1  clears sticky error flags.

Function
REQ-019 The staging FSM SHALL have two states: STG_EMPTY and STG_FULL.
- sub_tx SHALL equal DUMMY_BYTE in STG_EMPTY and the staging register in STG_FULL.
REQ-020 In STG_EMPTY, when the TX FIFO is non-empty, the FSM SHALL pop the head into the staging register and enter STG_FULL on the same edge (1-cycle latency).
REQ-021 In STG_FULL with load_from_fifo=1:
- TX FIFO non-empty: SHALL pop the head into staging the same edge and remain in STG_FULL.
- TX FIFO empty: SHALL go to STG_EMPTY.
REQ-022 load_from_fifo=1 in STG_EMPTY SHALL raise tx_underflow. The shifter consumes DUMMY_BYTE; the state is unchanged except for the REQ-020 refill.
REQ-023 tx_ready SHALL equal (tx_level<DEPTH). A push and a staging pop in the same cycle SHALL both occur, with the level unchanged.
REQ-024 fifo_load=1 SHALL push sub_rx into the RX FIFO if not full, or if full with a host pop in the same cycle (push and pop both occur).
- Otherwise the byte SHALL be dropped and rx_overflow raised.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; levels SHALL span 0..DEPTH with no wrap.
REQ-026 Host-side signals SHALL be independent of ss_pad_i; deselect mid-byte SHALL NOT flush either FIFO or the staging register.
REQ-027 rx_data SHALL be valid the same cycle rx_valid is high (first-word fall-through).

Reset
REQ-028 On presetn=0 at a pclk edge:
- FSM=STG_EMPTY; pointers and levels 0; tx_ready=1; rx_valid=0; sub_tx=DUMMY_BYTE; error flags 0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered bytes. Inputs SHALL be ignored while presetn=0.

Configuration
REQ-030 Macro SPI_SUB_ERR_STICKY_EN defined: tx_underflow/rx_overflow SHALL set and hold until an err_clr=1 edge. Set wins over a simultaneous err_clr.
REQ-031 Macro SPI_SUB_ERR_STICKY_EN undefined: flags SHALL be single-cycle pulses in the cycle after the event, and err_clr SHALL be ignored (port retained).

Structure
REQ-032 Package spi_sub_pkg SHALL hold the DEPTH default, the DUMMY_BYTE default, and the staging state enum (STG_EMPTY, STG_FULL).
REQ-033 A sub-module spi_sub_sync_fifo SHALL implement a parameterized FWFT FIFO (push, pop, full, empty, level). It SHALL be instantiated twice (TX, RX).

Verification
REQ-034 Push 8'hA5, 8'h3C with no pulses -> sub_tx=8'hA5 one cycle after the first push; tx_level=1.
REQ-035 Pulse load_from_fifo twice with 8'hA5, 8'h3C queued -> sub_tx: A5 -> 3C -> FF; third pulse raises tx_underflow.
REQ-036 Pulse fifo_load DEPTH+1 times with sub_rx=8'h10..8'h18 (DEPTH=8) -> rx_level=8; byte 8'h18 dropped; rx_overflow set.
REQ-037 RX full plus rx_ready and fifo_load in the same cycle -> rx_level stays 8, no overflow; the new byte is last in order.
REQ-038 Sticky build: after underflow, flag held for 10 cycles, clears on err_clr. Non-sticky build: 1-cycle pulse.
REQ-039 presetn=0 with 3 TX and 2 RX bytes queued -> next edge: levels 0, sub_tx=8'hFF, tx_ready=1, rx_valid=0.

Source files
------------

// File: rtl/spi_sub_pkg.sv
// Shared defaults and staging-state encoding for the SPI subordinate buffer controller.
package spi_sub_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned DEPTH_DEF      = 8;
    localparam logic [7:0]  DUMMY_BYTE_DEF = 8'hFF;

    typedef enum logic {
        STG_EMPTY = 1'b0,
        STG_FULL  = 1'b1
    } stg_state_e;

endpackage

// File: rtl/spi_sub_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module spi_sub_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; level never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spi_sub_buf_ctrl.sv
// Host-side TX/RX byte buffering and TX staging for an SPI subordinate shifter.
// Define SPI_SUB_ERR_STICKY_EN for sticky error flags cleared by err_clr.
module spi_sub_buf_ctrl
    import spi_sub_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter logic [7:0]  DUMMY_BYTE = DUMMY_BYTE_DEF
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [7:0]             sub_tx,
    input  logic                   load_from_fifo,
    input  logic [7:0]             sub_rx,
    input  logic                   fifo_load,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   tx_underflow,
    output logic                   rx_overflow,
    input  logic                   err_clr
);

    stg_state_e      stg_state;
    logic [7:0]      tx_head;
    logic            tx_full;
    logic            tx_empty;
    logic            tx_push;
    logic            tx_pop;
    logic            rx_full;
    logic            rx_empty;
    logic            rx_push;
    logic            rx_pop;
    logic            underflow_evt;
    logic            overflow_evt;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = !tx_empty && ((stg_state == STG_EMPTY) || load_from_fifo);
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_push  = fifo_load && (!rx_full || rx_pop);

    assign underflow_evt = load_from_fifo && (stg_state == STG_EMPTY);
    assign overflow_evt  = fifo_load && !rx_push;

    spi_sub_sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
        .clk   (pclk),
        .rst_n (presetn),
        .push  (tx_push),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    spi_sub_sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
        .clk   (pclk),
        .rst_n (presetn),
        .push  (rx_push),
        .wdata (sub_rx),
        .pop   (rx_pop),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    // Staging FSM; sub_tx is the registered staging byte (DUMMY_BYTE while empty).
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            stg_state <= STG_EMPTY;
            sub_tx    <= DUMMY_BYTE;
        end else begin
            if (tx_pop) begin
                stg_state <= STG_FULL;
                sub_tx    <= tx_head;
            end else if (load_from_fifo) begin
                stg_state <= STG_EMPTY;
                sub_tx    <= DUMMY_BYTE;
            end
        end
    end

`ifdef SPI_SUB_ERR_STICKY_EN
    // A new event wins over a simultaneous clear.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tx_underflow <= 1'b0;
            rx_overflow  <= 1'b0;
        end else begin
            tx_underflow <= underflow_evt || (tx_underflow && !err_clr);
            rx_overflow  <= overflow_evt  || (rx_overflow  && !err_clr);
        end
    end
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tx_underflow <= 1'b0;
            rx_overflow  <= 1'b0;
        end else begin
            tx_underflow <= underflow_evt;
            rx_overflow  <= overflow_evt;
        end
    end
`endif

endmodule

// File: tb/tb_spi_sub_buf_ctrl.sv
// Scoreboard bench for spi_sub_buf_ctrl: consumed TX bytes and popped RX bytes are
// checked by monitors against expected queues; levels and flags are checked directly.
module tb_spi_sub_buf_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          pclk;
    logic          presetn;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    sub_tx;
    logic          load_from_fifo;
    logic [7:0]    sub_rx;
    logic          fifo_load;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          tx_underflow;
    logic          rx_overflow;
    logic          err_clr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] tx_exp_q [$];
    logic [7:0] rx_exp_q [$];

    spi_sub_buf_ctrl #(.DEPTH(DEPTH), .DUMMY_BYTE(8'hFF)) dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .sub_tx         (sub_tx),
        .load_from_fifo (load_from_fifo),
        .sub_rx         (sub_rx),
        .fifo_load      (fifo_load),
        .tx_level       (tx_level),
        .rx_level       (rx_level),
        .tx_underflow   (tx_underflow),
        .rx_overflow    (rx_overflow),
        .err_clr        (err_clr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #2;
    endtask

    // TX monitor: byte the shifter consumes on each load_from_fifo pulse.
    always @(negedge pclk) begin
        if (presetn && load_from_fifo) begin
            if (tx_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_consume_unexpected: got 0x%0h expected none at %0t", sub_tx, $time);
            end else begin
                check("tx_consume", 32'(sub_tx), 32'(tx_exp_q.pop_front()));
            end
        end
    end

    // RX monitor: byte the host pops on each rx_valid & rx_ready.
    always @(negedge pclk) begin
        if (presetn && rx_valid && rx_ready) begin
            if (rx_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_pop_unexpected: got 0x%0h expected none at %0t", rx_data, $time);
            end else begin
                check("rx_pop", 32'(rx_data), 32'(rx_exp_q.pop_front()));
            end
        end
    end

    initial begin
        presetn = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        load_from_fifo = 1'b0; sub_rx = '0; fifo_load = 1'b0; err_clr = 1'b0;
        step(2);
        check("rst_tx_level", 32'(tx_level), 0);
        check("rst_rx_level", 32'(rx_level), 0);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_sub_tx", 32'(sub_tx), 32'h FF);
        check("rst_flags", 32'({tx_underflow, rx_overflow}), 0);
        presetn = 1'b1;
        step(1);

        // Two pushes: first byte staged one cycle after its push.
        tx_valid = 1'b1; tx_data = 8'hA5;
        step(1);
        tx_data = 8'h3C;
        step(1);
        tx_valid = 1'b0;
        check("stage_a5", 32'(sub_tx), 32'hA5);
        check("stage_level", 32'(tx_level), 1);

        // Three consumes: A5, 3C, then dummy with underflow.
        tx_exp_q.push_back(8'hA5); tx_exp_q.push_back(8'h3C); tx_exp_q.push_back(8'hFF);
        load_from_fifo = 1'b1;
        step(3);
        load_from_fifo = 1'b0;
        check("underflow_set", 32'(tx_underflow), 1);
        check("drain_sub_tx", 32'(sub_tx), 32'hFF);
`ifdef SPI_SUB_ERR_STICKY_EN
        step(10);
        check("underflow_held", 32'(tx_underflow), 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("underflow_cleared", 32'(tx_underflow), 0);
`else
        step(1);
        check("underflow_pulse_end", 32'(tx_underflow), 0);
`endif

        // Push and staging pop on the same edge keep tx_level unchanged.
        tx_valid = 1'b1; tx_data = 8'h11;
        step(1);
        tx_data = 8'h22;
        step(1);
        tx_valid = 1'b0;
        check("pp_pre_level", 32'(tx_level), 1);
        tx_exp_q.push_back(8'h11); tx_exp_q.push_back(8'h22); tx_exp_q.push_back(8'h33);
        tx_valid = 1'b1; tx_data = 8'h33; load_from_fifo = 1'b1;
        step(1);
        tx_valid = 1'b0; load_from_fifo = 1'b0;
        check("pp_level", 32'(tx_level), 1);
        check("pp_sub_tx", 32'(sub_tx), 32'h22);
        load_from_fifo = 1'b1;
        step(2);
        load_from_fifo = 1'b0;
        check("pp_drained", 32'(sub_tx), 32'hFF);
        check("pp_no_underflow", 32'(tx_underflow), 0);

        // Fill TX: staging plus DEPTH FIFO entries.
        tx_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            tx_data = 8'h40 + 8'(i);
            tx_exp_q.push_back(tx_data);
            step(1);
        end
        tx_data = 8'hBB;
        step(1);
        tx_valid = 1'b0;
        check("txfull_level", 32'(tx_level), DEPTH);
        check("txfull_ready", 32'(tx_ready), 0);
        check("txfull_sub_tx", 32'(sub_tx), 32'h40);
        load_from_fifo = 1'b1;
        step(DEPTH + 1);
        load_from_fifo = 1'b0;
        check("txfull_drained", 32'(sub_tx), 32'hFF);
        check("txfull_ready_back", 32'(tx_ready), 1);

        // RX overflow: DEPTH+1 bytes with host stalled, last one dropped.
        fifo_load = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            sub_rx = 8'h10 + 8'(i);
            if (i < DEPTH) rx_exp_q.push_back(sub_rx);
            step(1);
        end
        fifo_load = 1'b0;
        check("rxovf_level", 32'(rx_level), DEPTH);
        check("rxovf_flag", 32'(rx_overflow), 1);
        check("rxovf_head", 32'(rx_data), 32'h10);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("rxovf_cleared", 32'(rx_overflow), 0);

        // Full RX with simultaneous host pop and load: accepted, placed last.
        rx_exp_q.push_back(8'h55);
        rx_ready = 1'b1; fifo_load = 1'b1; sub_rx = 8'h55;
        step(1);
        rx_ready = 1'b0; fifo_load = 1'b0;
        check("rxpp_level", 32'(rx_level), DEPTH);
        check("rxpp_no_ovf", 32'(rx_overflow), 0);
        rx_ready = 1'b1;
        step(DEPTH);
        rx_ready = 1'b0;
        check("rx_drained_valid", 32'(rx_valid), 0);
        check("rx_drained_level", 32'(rx_level), 0);

        // Reset mid-operation discards 3 TX and 2 RX bytes and ignores inputs.
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'h61 + 8'(i);
            step(1);
        end
        tx_valid = 1'b0;
        fifo_load = 1'b1; sub_rx = 8'h71;
        step(1);
        sub_rx = 8'h72;
        step(1);
        fifo_load = 1'b0;
        check("prerst_tx_level", 32'(tx_level), 3);
        check("prerst_rx_level", 32'(rx_level), 2);
        check("prerst_sub_tx", 32'(sub_tx), 32'h61);
        presetn = 1'b0; tx_valid = 1'b1; tx_data = 8'hEE; fifo_load = 1'b1; sub_rx = 8'hEE;
        step(2);
        check("mrst_tx_level", 32'(tx_level), 0);
        check("mrst_rx_level", 32'(rx_level), 0);
        check("mrst_sub_tx", 32'(sub_tx), 32'hFF);
        check("mrst_tx_ready", 32'(tx_ready), 1);
        check("mrst_rx_valid", 32'(rx_valid), 0);
        tx_valid = 1'b0; fifo_load = 1'b0;
        presetn = 1'b1;
        step(1);
        check("post_rst_rx_valid", 32'(rx_valid), 0);

        // Fresh byte after reset goes straight to staging.
        tx_valid = 1'b1; tx_data = 8'h99;
        step(1);
        tx_valid = 1'b0;
        step(1);
        check("post_rst_stage", 32'(sub_tx), 32'h99);
        check("post_rst_level", 32'(tx_level), 0);
        tx_exp_q.push_back(8'h99);
        load_from_fifo = 1'b1;
        step(1);
        load_from_fifo = 1'b0;
        check("post_rst_drain", 32'(sub_tx), 32'hFF);

        step(2);
        check("tx_queue_empty", 32'(tx_exp_q.size()), 0);
        check("rx_queue_empty", 32'(rx_exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
